serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller that drives a single full-adder bit slice
//   (OP_A/OP_B/CIN -> SUM/CO), one bit per clock, LSB first.
//   Sits directly upstream of the adder stage, feeding it operand bits.
//   Sits downstream of it as well, collecting each SUM bit and the rippled
//   carry into a WIDTH-bit result.
//   Used where area matters more than latency; the result is handed off
//   with a one-cycle DONE pulse.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits
// PORTS
//   CLK     in   1      rising-edge clock, the only clock
//   RST     in   1      synchronous, active-high reset
//   START   in   1      request an add; accepted only in IDLE
//   OP_A    in   WIDTH  operand A, sampled on the accepted START edge
//   OP_B    in   WIDTH  operand B, sampled on the accepted START edge
//   CIN     in   1      carry-in, sampled on the accepted START edge
//   BUSY    out  1      high in ADD and DONE states
//   DONE    out  1      one-cycle pulse; SUM/CO valid from this cycle on
//   SUM     out  WIDTH  result register, (A+B+CIN) mod 2^WIDTH
//   CO      out  1      carry-out of bit WIDTH-1
// BEHAVIOUR
//   Clocking and reset
//   - Everything is on posedge CLK. RST has priority over all other inputs.
//   - On RST: state=IDLE, BUSY=0, DONE=0, SUM=0, CO=0, bit counter=0,
//     carry FF=0, operand shift regs=0.
//   - RST mid-operation aborts the add; no DONE is produced for it.
//   States: IDLE -> ADD -> DONE -> IDLE
//   - IDLE, START=1: latch OP_A/OP_B into shift regs, carry FF<=CIN,
//     count<=0, go to ADD.
//   - IDLE, START=0: stay in IDLE.
//   - ADD, each cycle i = 0..WIDTH-1:
//     - Slice inputs are a=A_sr[0], b=B_sr[0], c=carry FF.
//     - s = a^b^c; carry FF <= (a&b)|(c&(a^b)).
//     - s shifts into the MSB of the working sum reg; A_sr and B_sr shift right.
//     - count++.
//   - ADD, count==WIDTH-1: after that cycle's update, go to DONE.
//   - DONE, single cycle:
//     - DONE=1; SUM<=working sum, CO<=carry FF (both registered on DONE entry).
//     - Always returns to IDLE.
//   Timing and handshake
//   - START accepted at edge 0 -> WIDTH ADD cycles -> DONE high in cycle WIDTH+1.
//   - At most one add is in flight: START while BUSY=1 (ADD or DONE) is ignored;
//     operands are not re-sampled.
//   - Earliest next accept is the first IDLE cycle after DONE, so back-to-back
//     throughput is one add per WIDTH+2 cycles.
//   Outputs and arithmetic
//   - SUM/CO hold their values until the next DONE or RST. They are not
//     cleared by a new START.
//   - Arithmetic is unsigned. Overflow wraps mod 2^WIDTH and is reported only
//     via CO; no saturation.
//   - BUSY is registered: 1 from the cycle after an accepted START through the
//     DONE cycle inclusive.
// TESTING (WIDTH=8)
//   1) A=3, B=5, CIN=0, START pulse -> BUSY high 9 cycles, DONE at cycle 9;
//      SUM=8, CO=0.
//   2) A=255, B=1, CIN=0 -> SUM=0, CO=1; 255+255 with CIN=1 -> SUM=255, CO=1.
//   3) START held high continuously, A=10, B=20 -> exactly one DONE per 10
//      cycles; operand change during BUSY ignored, SUM=30.
//   4) RST asserted in the 4th ADD cycle -> next edge: IDLE, BUSY=0, SUM=0,
//      CO=0; no DONE pulse follows.
//   5) After test 1, 9 idle cycles with START=0 -> SUM stays 8, DONE stays 0;
//      then A=0, B=0 -> SUM=0, CO=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the serial adder controller and its requester.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             CO;

    modport master (
        output START, OP_A, OP_B, CIN,
        input  BUSY, DONE, SUM, CO
    );

    modport slave (
        input  START, OP_A, OP_B, CIN,
        output BUSY, DONE, SUM, CO
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused LSB first over WIDTH cycles,
// result published with a one-cycle DONE pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;

    logic slice_a, slice_b, slice_s, slice_co;

    always_comb begin
        slice_a  = a_sr_q[0];
        slice_b  = b_sr_q[0];
        slice_s  = slice_a ^ slice_b ^ carry_q;
        slice_co = (slice_a & slice_b) | (carry_q & (slice_a ^ slice_b));

        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        work_d  = work_q;
        sum_d   = sum_q;
        co_d    = co_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    a_sr_d  = bus.OP_A;
                    b_sr_d  = bus.OP_B;
                    carry_d = bus.CIN;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                work_d  = {slice_s, work_q[WIDTH-1:1]};
                carry_d = slice_co;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // The last slice result goes straight into SUM/CO so they are valid with DONE.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {slice_s, work_q[WIDTH-1:1]};
                    co_d    = slice_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    assign bus.BUSY = (state_q != ST_IDLE);
    assign bus.DONE = (state_q == ST_DONE);
    assign bus.SUM  = sum_q;
    assign bus.CO   = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: expected results queued at issue time,
// popped and compared by a monitor whenever DONE is seen.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [W:0] exp_q[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.DONE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(bus.SUM), 32'(e[W:1]));
                check("sb_co", 32'(bus.CO), 32'(e[0]));
            end
        end
    end

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int busy_n;
        int done_n;
        int done_at;
        logic [W:0] full;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_q.push_back({full[W-1:0], full[W]});
        bus.OP_A  = a;
        bus.OP_B  = b;
        bus.CIN   = c;
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        for (int k = 1; k <= W + 3; k++) begin
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(busy_n), 32'(W + 1));
        check("done_cycle", 32'(done_at), 32'(W + 1));
        check("done_pulses", 32'(done_n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_n;
        int first_done;
        int last_done;
        total = 0;
        bad   = 0;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.OP_A  = '0;
        bus.OP_B  = '0;
        bus.CIN   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_sum", 32'(bus.SUM), 32'd0);
        check("rst_co", 32'(bus.CO), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] 3 + 5");
        apply_stimulus(8'd3, 8'd5, 1'b0);

        // Idle stretch: result must hold, no spurious DONE.
        done_n = 0;
        for (int k = 0; k < 9; k++) begin
            if (bus.DONE) done_n++;
            @(posedge clk); #1;
        end
        check("idle_done", 32'(done_n), 32'd0);
        check("idle_sum", 32'(bus.SUM), 32'd8);
        check("idle_co", 32'(bus.CO), 32'd0);

        $display("[TB] 0 + 0, 255 + 1, 255 + 255 + 1");
        apply_stimulus(8'd0, 8'd0, 1'b0);
        apply_stimulus(8'd255, 8'd1, 1'b0);
        apply_stimulus(8'd255, 8'd255, 1'b1);
        apply_stimulus(8'd170, 8'd85, 1'b1);

        $display("[TB] START held high");
        repeat (3) exp_q.push_back({8'd30, 1'b0});
        bus.OP_A  = 8'd10;
        bus.OP_B  = 8'd20;
        bus.CIN   = 1'b0;
        bus.START = 1'b1;
        @(posedge clk); #1;
        done_n     = 0;
        first_done = 0;
        last_done  = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                bus.OP_A = 8'd77;
                bus.OP_B = 8'd88;
                bus.CIN  = 1'b1;
            end
            if (k == 8) begin
                bus.OP_A = 8'd10;
                bus.OP_B = 8'd20;
                bus.CIN  = 1'b0;
            end
            if (bus.DONE) begin
                done_n++;
                if (first_done == 0) first_done = k;
                last_done = k;
            end
            if (k < 30) begin
                @(posedge clk); #1;
            end
        end
        bus.START = 1'b0;
        check("hold_done_pulses", 32'(done_n), 32'd3);
        check("hold_first_done", 32'(first_done), 32'd9);
        check("hold_last_done", 32'(last_done), 32'd29);
        check("hold_sum", 32'(bus.SUM), 32'd30);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset during ADD");
        bus.OP_A  = 8'd100;
        bus.OP_B  = 8'd50;
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(bus.BUSY), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_done", 32'(bus.DONE), 32'd0);
        check("abort_sum", 32'(bus.SUM), 32'd0);
        check("abort_co", 32'(bus.CO), 32'd0);
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (bus.DONE) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
